// File: rtl/addertree_pipe_acc.sv
// Pipelined signed reduction tree feeding a grouped accumulator.
// Each beat of NUM_IN products is registered, reduced pairwise over LVL
// registered levels, then folded into a per-window accumulator that emits
// one result pulse when the closing beat arrives.
module addertree_pipe_acc #(
  parameter int NUM_IN = 9,
  parameter int IN_W   = 16,
  parameter int ACC_W  = 32,
  parameter int SAT    = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic                     in_first,
  input  logic                     in_last,
  input  logic [NUM_IN*IN_W-1:0]   in_data,
  output logic                     out_valid,
  output logic signed [ACC_W-1:0]  out_data,
  output logic                     out_ovf
);

  localparam int LVL = $clog2(NUM_IN);
  localparam int TW  = IN_W + LVL;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Input rank, then one rank per tree level. Sideband index 0 is the input
  // rank and index LVL is the rank presented to the accumulator.
  logic signed [IN_W-1:0] inQ   [NUM_IN];
  logic signed [TW-1:0]   treeQ [LVL][NUM_IN];
  logic signed [TW-1:0]   nodeD [LVL][2*NUM_IN];
  logic [LVL:0]           vldQ;
  logic [LVL:0]           firstQ;
  logic [LVL:0]           lastQ;

  logic signed [ACC_W-1:0] accQ, accD;
  logic                    ovfQ, ovfD;
  logic                    outValidQ, outValidD;
  logic signed [ACC_W-1:0] outDataQ, outDataD;
  logic                    outOvfQ, outOvfD;

  logic signed [ACC_W-1:0] treeSum, baseVal, rawSum, accNew;
  logic                    ovfThis, stickyNew;

  // Capture the raw products so the tree starts from a registered operand set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_IN; i++) inQ[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) inQ[i] <= in_data[i*IN_W +: IN_W];
    end
  end

  // Operand view of each level, zero-padded so an odd leftover element adds
  // zero and therefore passes through unchanged.
  always_comb begin
    for (int l = 0; l < LVL; l++) begin
      for (int j = 0; j < 2*NUM_IN; j++) nodeD[l][j] = '0;
    end
    for (int j = 0; j < NUM_IN; j++) nodeD[0][j] = TW'(inQ[j]);
    for (int l = 1; l < LVL; l++) begin
      for (int j = 0; j < NUM_IN; j++) nodeD[l][j] = treeQ[l-1][j];
    end
  end

  // Pairwise signed adds, registered after every level at full tree width.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int l = 0; l < LVL; l++) begin
        for (int j = 0; j < NUM_IN; j++) treeQ[l][j] <= '0;
      end
    end else begin
      for (int l = 0; l < LVL; l++) begin
        for (int j = 0; j < NUM_IN; j++) treeQ[l][j] <= nodeD[l][2*j] + nodeD[l][2*j+1];
      end
    end
  end

  // Sideband shift register; flags are qualified by valid and flushed by clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vldQ   <= '0;
      firstQ <= '0;
      lastQ  <= '0;
    end else if (clear) begin
      vldQ   <= '0;
      firstQ <= '0;
      lastQ  <= '0;
    end else begin
      vldQ   <= {vldQ[LVL-1:0],   in_valid};
      firstQ <= {firstQ[LVL-1:0], in_valid & in_first};
      lastQ  <= {lastQ[LVL-1:0],  in_valid & in_last};
    end
  end

  // Accumulate the tree sum, detect signed overflow and optionally clamp.
  always_comb begin
    treeSum   = ACC_W'(treeQ[LVL-1][0]);
    baseVal   = firstQ[LVL] ? '0 : accQ;
    rawSum    = baseVal + treeSum;
    ovfThis   = (baseVal[ACC_W-1] == treeSum[ACC_W-1]) &&
                (rawSum[ACC_W-1] != baseVal[ACC_W-1]);
    accNew    = rawSum;
    if ((SAT != 0) && ovfThis) accNew = baseVal[ACC_W-1] ? ACC_MIN : ACC_MAX;
    stickyNew = (firstQ[LVL] ? 1'b0 : ovfQ) | ovfThis;

    accD      = accQ;
    ovfD      = ovfQ;
    outValidD = 1'b0;
    outDataD  = outDataQ;
    outOvfD   = outOvfQ;
    if (vldQ[LVL]) begin
      accD = accNew;
      ovfD = stickyNew;
      if (lastQ[LVL]) begin
        outValidD = 1'b1;
        outDataD  = accNew;
        outOvfD   = stickyNew;
      end
    end
  end

  // Accumulator and result registers; clear wins over an arriving beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      accQ      <= '0;
      ovfQ      <= 1'b0;
      outValidQ <= 1'b0;
      outDataQ  <= '0;
      outOvfQ   <= 1'b0;
    end else if (clear) begin
      accQ      <= '0;
      ovfQ      <= 1'b0;
      outValidQ <= 1'b0;
    end else begin
      accQ      <= accD;
      ovfQ      <= ovfD;
      outValidQ <= outValidD;
      outDataQ  <= outDataD;
      outOvfQ   <= outOvfD;
    end
  end

  assign out_valid = outValidQ;
  assign out_data  = outDataQ;
  assign out_ovf   = outOvfQ;

endmodule

// File: tb/tb_addertree_pipe_acc.sv
// Directed bench: a 32-bit saturating instance plus 20-bit saturating and
// wrapping instances sharing the same stimulus for the overflow cases.
module tb_addertree_pipe_acc;

  logic         clk;
  logic         resetN;
  logic         clear;
  logic         inValid;
  logic         inFirst;
  logic         inLast;
  logic [143:0] inData;

  logic         outValid, outValidS, outValidW;
  logic [31:0]  outData;
  logic [19:0]  outDataS, outDataW;
  logic         outOvf, outOvfS, outOvfW;

  int checkCount = 0;
  int passCount  = 0;
  int pulses;

  localparam logic [19:0] SAT_EXP  = 20'h7FFFF;
  localparam logic [19:0] WRAP_EXP = 20'd589788;

  addertree_pipe_acc #(.NUM_IN(9), .IN_W(16), .ACC_W(32), .SAT(1)) dut (
    .clk(clk), .reset_n(resetN), .clear(clear), .in_valid(inValid),
    .in_first(inFirst), .in_last(inLast), .in_data(inData),
    .out_valid(outValid), .out_data(outData), .out_ovf(outOvf));

  addertree_pipe_acc #(.NUM_IN(9), .IN_W(16), .ACC_W(20), .SAT(1)) dutS (
    .clk(clk), .reset_n(resetN), .clear(clear), .in_valid(inValid),
    .in_first(inFirst), .in_last(inLast), .in_data(inData),
    .out_valid(outValidS), .out_data(outDataS), .out_ovf(outOvfS));

  addertree_pipe_acc #(.NUM_IN(9), .IN_W(16), .ACC_W(20), .SAT(0)) dutW (
    .clk(clk), .reset_n(resetN), .clear(clear), .in_valid(inValid),
    .in_first(inFirst), .in_last(inLast), .in_data(inData),
    .out_valid(outValidW), .out_data(outDataW), .out_ovf(outOvfW));

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs from a negedge; elements 0..7 get elem, element 8 gets elem8.
  task automatic applyStimulus(input logic v, input logic f, input logic l,
                               input int elem, input int elem8, input logic clr);
    inValid = v;
    inFirst = f;
    inLast  = l;
    clear   = clr;
    for (int i = 0; i < 8; i++) inData[i*16 +: 16] = 16'(elem);
    inData[8*16 +: 16] = 16'(elem8);
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
                tag, $signed(observed), observed, $signed(expected), expected);
  endtask

  // Linear sequence of directed steps.
  initial begin
    resetN  = 1'b0;
    clear   = 1'b0;
    inValid = 1'b0;
    inFirst = 1'b0;
    inLast  = 1'b0;
    inData  = '0;
    @(negedge clk);
    checkOutput("rst_valid", 32'(outValid), 32'd0);
    checkOutput("rst_data",  outData, 32'd0);
    checkOutput("rst_ovf",   32'(outOvf), 32'd0);
    resetN = 1'b1;
    idleCycles(2);

    // single beat of all ones: pulse exactly five edges later
    applyStimulus(1'b1, 1'b1, 1'b1, 1, 1, 1'b0);
    idleCycles(4);
    checkOutput("ones_early", 32'(outValid), 32'd0);
    idleCycles(1);
    checkOutput("ones_valid", 32'(outValid), 32'd1);
    checkOutput("ones_data",  outData, 32'd9);
    checkOutput("ones_ovf",   32'(outOvf), 32'd0);
    idleCycles(1);
    checkOutput("ones_pulse_end", 32'(outValid), 32'd0);
    checkOutput("ones_hold",      outData, 32'd9);

    // mixed signs: eight x -32768 plus one 32767
    applyStimulus(1'b1, 1'b1, 1'b1, -32768, 32767, 1'b0);
    idleCycles(5);
    checkOutput("mixed_valid", 32'(outValid), 32'd1);
    checkOutput("mixed_data",  outData, 32'(-229377));

    // three beats of 100 with a bubble before the last
    applyStimulus(1'b1, 1'b1, 1'b0, 100, 100, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 100, 100, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 100, 100, 1'b0);
    idleCycles(4);
    checkOutput("grp3_early", 32'(outValid), 32'd0);
    idleCycles(1);
    checkOutput("grp3_valid", 32'(outValid), 32'd1);
    checkOutput("grp3_data",  outData, 32'd2700);

    // six back-to-back single-beat groups
    for (int k = 1; k <= 6; k++) applyStimulus(1'b1, 1'b1, 1'b1, k, k, 1'b0);
    checkOutput("b2b_valid_1", 32'(outValid), 32'd1);
    checkOutput("b2b_data_1",  outData, 32'd9);
    for (int k = 2; k <= 6; k++) begin
      idleCycles(1);
      checkOutput($sformatf("b2b_valid_%0d", k), 32'(outValid), 32'd1);
      checkOutput($sformatf("b2b_data_%0d", k),  outData, 32'(9*k));
    end
    idleCycles(1);
    checkOutput("b2b_end", 32'(outValid), 32'd0);

    // four beats of 16383: overflows the 20-bit instances only
    applyStimulus(1'b1, 1'b1, 1'b0, 16383, 16383, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16383, 16383, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16383, 16383, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 16383, 16383, 1'b0);
    idleCycles(5);
    checkOutput("sat_valid", 32'(outValidS), 32'd1);
    checkOutput("sat_data",  {12'b0, outDataS}, {12'b0, SAT_EXP});
    checkOutput("sat_ovf",   32'(outOvfS), 32'd1);
    checkOutput("wrap_data", {12'b0, outDataW}, {12'b0, WRAP_EXP});
    checkOutput("wrap_ovf",  32'(outOvfW), 32'd1);
    checkOutput("wide_data", outData, 32'd589788);
    checkOutput("wide_ovf",  32'(outOvf), 32'd0);

    // a clean group afterwards reports no overflow
    applyStimulus(1'b1, 1'b1, 1'b1, 1, 1, 1'b0);
    idleCycles(5);
    checkOutput("clean_sat_data", {12'b0, outDataS}, 32'd9);
    checkOutput("clean_sat_ovf",  32'(outOvfS), 32'd0);
    checkOutput("clean_wrap_ovf", 32'(outOvfW), 32'd0);

    // clear while the group is still in flight: no pulse for it
    applyStimulus(1'b1, 1'b1, 1'b0, 5, 5, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 5, 5, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 5, 5, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      idleCycles(1);
      if (outValid) pulses++;
    end
    checkOutput("clear_no_pulse", 32'(pulses), 32'd0);
    checkOutput("clear_hold",     outData, 32'd9);
    applyStimulus(1'b1, 1'b1, 1'b1, 2, 2, 1'b0);
    idleCycles(5);
    checkOutput("after_clear_valid", 32'(outValid), 32'd1);
    checkOutput("after_clear_data",  outData, 32'd18);

    // async reset mid-group clears outputs immediately, no stale pulse after
    applyStimulus(1'b1, 1'b1, 1'b1, 3, 3, 1'b0);
    idleCycles(2);
    resetN = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(outValid), 32'd0);
    checkOutput("mid_rst_data",  outData, 32'd0);
    checkOutput("mid_rst_ovf",   32'(outOvf), 32'd0);
    @(negedge clk);
    resetN = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      idleCycles(1);
      if (outValid) pulses++;
    end
    checkOutput("post_rst_no_pulse", 32'(pulses), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
